// File: rtl/golife_pkg.sv
// Shared definitions for the golife Game of Life engine.
// Configuration macro: GOLIFE_TORUS_EN (consumed by golife.sv).
package golife_pkg;

   localparam int unsigned NBR_W = 4;

   typedef logic [NBR_W-1:0] nbr_cnt_t;

   // Conway rule: birth on exactly 3 neighbours, survival on 2 or 3.
   function automatic logic life_rule(input logic alive, input nbr_cnt_t n);
      return (n == nbr_cnt_t'(3)) || (alive && (n == nbr_cnt_t'(2)));
   endfunction

endpackage

// File: rtl/golife_cell.sv
// One board cell: a single state flop plus its neighbour counter.
module golife_cell
   import golife_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       run,
   input  logic       init,
   input  logic [7:0] nbr,
   output logic       alive
);

   nbr_cnt_t cnt;

   // Population count of the eight neighbour bits.
   always_comb begin
      cnt = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         cnt = cnt + nbr_cnt_t'(nbr[i]);
      end
   end

   // Cell state: reset > load > run > hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alive <= 1'b0;
      end else if (load) begin
         alive <= init;
      end else if (run) begin
         alive <= life_rule(alive, cnt);
      end
   end

endmodule

// File: rtl/golife.sv
// Game of Life engine: SIDEWIDTH x SIDEWIDTH array of golife_cell.
// Configuration macro: GOLIFE_TORUS_EN -- when defined, board edges wrap
// around; otherwise cells beyond the edge count as dead.
module golife
   import golife_pkg::*;
#(
   parameter int unsigned SIDEWIDTH = 16
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                load,
   input  logic                                run,
   input  logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] ingrid,
   output logic [SIDEWIDTH-1:0][SIDEWIDTH-1:0] grid
);

   typedef logic [SIDEWIDTH-1:0] row_t;

   row_t [SIDEWIDTH-1:0] board;

   // Board padded by one ring of cells so every cell sees a uniform
   // 3x3 window; the ring is either dead or a wrapped copy of the far edge.
   logic [SIDEWIDTH+1:0][SIDEWIDTH+1:0] pad;

   assign grid = board;

   for (genvar pr = 0; pr < SIDEWIDTH + 2; pr++) begin : g_pad_row
      for (genvar pc = 0; pc < SIDEWIDTH + 2; pc++) begin : g_pad_col
`ifdef GOLIFE_TORUS_EN
         assign pad[pr][pc] = board[(pr + SIDEWIDTH - 1) % SIDEWIDTH]
                                   [(pc + SIDEWIDTH - 1) % SIDEWIDTH];
`else
         if (pr >= 1 && pr <= SIDEWIDTH && pc >= 1 && pc <= SIDEWIDTH) begin : g_in
            assign pad[pr][pc] = board[pr-1][pc-1];
         end else begin : g_edge
            assign pad[pr][pc] = 1'b0;
         end
`endif
      end
   end

   for (genvar r = 0; r < SIDEWIDTH; r++) begin : g_row
      for (genvar c = 0; c < SIDEWIDTH; c++) begin : g_col
         golife_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .run   (run),
            .init  (ingrid[r][c]),
            .nbr   ({pad[r+2][c+2], pad[r+2][c+1], pad[r+2][c],
                     pad[r+1][c+2],                pad[r+1][c],
                     pad[r][c+2],   pad[r][c+1],   pad[r][c]}),
            .alive (board[r][c])
         );
      end
   end

endmodule

// File: tb/tb_golife.sv
// Directed testbench for golife with hand-computed expected boards.
module tb_golife;

   localparam int unsigned SW = 16;
   typedef logic [SW-1:0][SW-1:0] board_t;

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   logic   load = 1'b0;
   logic   run = 1'b0;
   board_t ingrid = '0;
   board_t grid;

   int checks = 0;
   int errors = 0;

   golife #(.SIDEWIDTH(SW)) dut (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .run    (run),
      .ingrid (ingrid),
      .grid   (grid)
   );

   always #5 clk = ~clk;

   task automatic load_board(input board_t b);
      ingrid = b;
      load   = 1'b1;
      @(posedge clk); #1;
      load   = 1'b0;
      ingrid = '0;
   endtask

   task automatic run_gens(input int n);
      run = 1'b1;
      repeat (n) begin
         @(posedge clk); #1;
      end
      run = 1'b0;
   endtask

   task automatic test_reset();
      board_t b;
      #2;
      checks++;
      if (grid !== '0) begin
         errors++;
         $display("FAIL reset_initial: got %h expected 0", grid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      b = '0;
      b[7] = 16'h01C0;
      load_board(b);
      run = 1'b1;
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      checks++;
      if (grid !== '0) begin
         errors++;
         $display("FAIL reset_async: got %h expected 0", grid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      run = 1'b0;
      checks++;
      if (grid !== '0) begin
         errors++;
         $display("FAIL reset_run_empty: got %h expected 0", grid);
      end
   endtask

   task automatic test_blinker();
      board_t h, v;
      h = '0;
      h[7] = 16'h01C0;
      v = '0;
      v[8] = 16'h0080;
      v[7] = 16'h0080;
      v[6] = 16'h0080;
      load_board(h);
      checks++;
      if (grid !== h) begin
         errors++;
         $display("FAIL blinker_load: got %h expected %h", grid, h);
      end
      run = 1'b1;
      for (int g = 1; g <= 1000; g++) begin
         @(posedge clk); #1;
         checks++;
         if (grid !== ((g % 2 == 1) ? v : h)) begin
            errors++;
            $display("FAIL blinker_gen%0d: got %h expected %h", g, grid,
                     (g % 2 == 1) ? v : h);
         end
      end
      run = 1'b0;
   endtask

   task automatic test_still();
      board_t b;
      b = '0;
      b[5] = 16'h0060;
      b[6] = 16'h0060;
      load_board(b);
      run_gens(50);
      checks++;
      if (grid !== b) begin
         errors++;
         $display("FAIL still_block: got %h expected %h", grid, b);
      end
   endtask

   task automatic test_glider();
      board_t b, e;
      b = '0;
      b[9] = 16'h0080;
      b[8] = 16'h0040;
      b[7] = 16'h01C0;
      e = '0;
      e[8] = 16'h0040;
      e[7] = 16'h0020;
      e[6] = 16'h00E0;
      load_board(b);
      run_gens(4);
      checks++;
      if (grid !== e) begin
         errors++;
         $display("FAIL glider_4gen: got %h expected %h", grid, e);
      end
   endtask

   task automatic test_edge();
      board_t b, e1, e2;
      b = '0;
      b[0] = 16'hE000;
      e1 = '0;
      e1[1] = 16'h4000;
      e1[0] = 16'h4000;
`ifdef GOLIFE_TORUS_EN
      e1[15] = 16'h4000;
      e2 = b;
`else
      e2 = '0;
`endif
      load_board(b);
      run_gens(1);
      checks++;
      if (grid !== e1) begin
         errors++;
         $display("FAIL edge_gen1: got %h expected %h", grid, e1);
      end
      run_gens(1);
      checks++;
      if (grid !== e2) begin
         errors++;
         $display("FAIL edge_gen2: got %h expected %h", grid, e2);
      end
   endtask

   task automatic test_priority();
      board_t b;
      b = '0;
      b[7] = 16'h01C0;
      b[12] = 16'h8001;
      ingrid = b;
      load = 1'b1;
      run  = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      run  = 1'b0;
      checks++;
      if (grid !== b) begin
         errors++;
         $display("FAIL prio_load_over_run: got %h expected %h", grid, b);
      end
      for (int i = 0; i < 20; i++) begin
         ingrid = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1;
         checks++;
         if (grid !== b) begin
            errors++;
            $display("FAIL prio_hold_c%0d: got %h expected %h", i, grid, b);
         end
      end
      ingrid = '0;
   endtask

   initial begin
      test_reset();
      test_blinker();
      test_still();
      test_glider();
      test_edge();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
